// File: rtl/air_hockey_scoreboard_if.sv
// Scoreboard interface: game-tick clock samples and goal flags in, score/status out.
// SCORE_SEVENSEG_EN adds the an/seg display drive.
interface air_hockey_scoreboard_if;
   logic       prev_clk_cursor;
   logic       clk_cursor;
   logic       collide1;
   logic       collide2;
   logic       restart;
   logic [7:0] score1;
   logic [7:0] score2;
   logic       freeze;
   logic       goal_flash;
   logic       puck_reset;
   logic       game_over;
   logic [1:0] winner;
   logic [1:0] state;
`ifdef SCORE_SEVENSEG_EN
   logic [3:0] an;
   logic [7:0] seg;
`endif

   modport slave (
      input  prev_clk_cursor, clk_cursor, collide1, collide2, restart,
      output score1, score2, freeze, goal_flash, puck_reset,
      output game_over, winner, state
`ifdef SCORE_SEVENSEG_EN
      , output an, seg
`endif
   );

   modport master (
      output prev_clk_cursor, clk_cursor, collide1, collide2, restart,
      input  score1, score2, freeze, goal_flash, puck_reset,
      input  game_over, winner, state
`ifdef SCORE_SEVENSEG_EN
      , input an, seg
`endif
   );
endinterface

// File: rtl/air_hockey_scoreboard.sv
// Air hockey score keeper: BCD scores, play/hold/over flow, puck reset pulse.
// Define SCORE_SEVENSEG_EN to add the multiplexed 7-segment score display.
module air_hockey_scoreboard #(
   parameter int WIN_SCORE    = 7,
   parameter int HOLD_TICKS   = 60,
   parameter int REFRESH_BITS = 17
) (
   input logic                    clk,
   input logic                    clr,
   air_hockey_scoreboard_if.slave bus
);
   localparam logic [1:0] S_PLAY = 2'b00;
   localparam logic [1:0] S_HOLD = 2'b01;
   localparam logic [1:0] S_OVER = 2'b10;

   localparam logic [7:0] WIN_BCD   = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
   localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

   if (WIN_SCORE < 1 || WIN_SCORE > 99 || HOLD_TICKS < 1 ||
       HOLD_TICKS > 255 || REFRESH_BITS < 2) begin : g_bad_param
      $error("air_hockey_scoreboard: parameter out of range");
   end

   logic [1:0] st;
   logic [7:0] hold_cnt;
   logic [7:0] score1_q, score2_q;
   logic       c1_q, c2_q;
   logic       freeze_q, goal_flash_q, puck_reset_q, game_over_q;
   logic [1:0] winner_q;
   logic       g1, g2, tick;
   logic [7:0] inc1, inc2;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign g1   = bus.collide1 & ~c1_q;
   assign g2   = bus.collide2 & ~c2_q;
   assign tick = ~bus.prev_clk_cursor & bus.clk_cursor;
   assign inc1 = bcd_inc(score1_q);
   assign inc2 = bcd_inc(score2_q);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         st           <= S_HOLD;
         hold_cnt     <= HOLD_INIT;
         score1_q     <= 8'h00;
         score2_q     <= 8'h00;
         c1_q         <= 1'b0;
         c2_q         <= 1'b0;
         freeze_q     <= 1'b1;
         goal_flash_q <= 1'b0;
         puck_reset_q <= 1'b0;
         game_over_q  <= 1'b0;
         winner_q     <= 2'b00;
      end else begin
         c1_q         <= bus.collide1;
         c2_q         <= bus.collide2;
         puck_reset_q <= 1'b0;
         case (st)
            S_PLAY: begin
               // left goal credits player 2, right goal credits player 1
               if (g1 && !g2) begin
                  score2_q <= inc2;
                  freeze_q <= 1'b1;
                  if (inc2 == WIN_BCD) begin
                     st          <= S_OVER;
                     winner_q    <= 2'b10;
                     game_over_q <= 1'b1;
                  end else begin
                     st           <= S_HOLD;
                     hold_cnt     <= HOLD_INIT;
                     goal_flash_q <= 1'b1;
                  end
               end else if (g2 && !g1) begin
                  score1_q <= inc1;
                  freeze_q <= 1'b1;
                  if (inc1 == WIN_BCD) begin
                     st          <= S_OVER;
                     winner_q    <= 2'b01;
                     game_over_q <= 1'b1;
                  end else begin
                     st           <= S_HOLD;
                     hold_cnt     <= HOLD_INIT;
                     goal_flash_q <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (tick) begin
                  if (hold_cnt <= 8'd1) begin
                     st           <= S_PLAY;
                     freeze_q     <= 1'b0;
                     puck_reset_q <= 1'b1;
                     goal_flash_q <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
               end
            end
            S_OVER: begin
               if (bus.restart) begin
                  st           <= S_HOLD;
                  hold_cnt     <= HOLD_INIT;
                  score1_q     <= 8'h00;
                  score2_q     <= 8'h00;
                  winner_q     <= 2'b00;
                  game_over_q  <= 1'b0;
                  goal_flash_q <= 1'b0;
               end
            end
            default: begin
               st       <= S_HOLD;
               hold_cnt <= HOLD_INIT;
               freeze_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.score1     = score1_q;
   assign bus.score2     = score2_q;
   assign bus.freeze     = freeze_q;
   assign bus.goal_flash = goal_flash_q;
   assign bus.puck_reset = puck_reset_q;
   assign bus.game_over  = game_over_q;
   assign bus.winner     = winner_q;
   assign bus.state      = st;

`ifdef SCORE_SEVENSEG_EN
   localparam logic [REFRESH_BITS-1:0] REF_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

   logic [REFRESH_BITS-1:0] refresh;
   logic [1:0]              sel;
   logic [3:0]              digit;
   logic                    blank;
   logic [3:0]              an_q;
   logic [7:0]              seg_q;

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         4'hA: return 8'h88;
         4'hB: return 8'h83;
         4'hC: return 8'hC6;
         4'hD: return 8'hA1;
         4'hE: return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   assign sel = refresh[REFRESH_BITS-1 -: 2];

   always_comb begin
      digit = 4'h0;
      case (sel)
         2'd0:    digit = score1_q[3:0];
         2'd1:    digit = score1_q[7:4];
         2'd2:    digit = score2_q[3:0];
         default: digit = score2_q[7:4];
      endcase
      // in OVER only the winner's digits stay lit
      blank = game_over_q &&
              ((winner_q == 2'b01 && sel[1]) || (winner_q == 2'b10 && !sel[1]));
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         refresh <= '0;
         an_q    <= 4'b1111;
         seg_q   <= 8'hFF;
      end else begin
         refresh <= refresh + REF_ONE;
         an_q    <= blank ? 4'b1111 : ~(4'b0001 << sel);
         seg_q   <= seg_of(digit);
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
`endif
endmodule

// File: tb/tb_air_hockey_scoreboard.sv
// Scoreboard bench: stimulus pushes expected status snapshots with their clk
// cycle; a negedge monitor pops one whenever the DUT's status changes.
module tb_air_hockey_scoreboard;
   localparam logic [1:0] PLAY = 2'b00;
   localparam logic [1:0] HOLD = 2'b01;
   localparam logic [1:0] OVER = 2'b10;
   localparam logic [7:0] WIN_BCD = 8'h12;

   typedef struct packed {
      logic [1:0] st;
      logic [7:0] s1;
      logic [7:0] s2;
      logic       frz;
      logic       gf;
      logic       pr;
      logic       go;
      logic [1:0] win;
   } snap_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;
   snap_t last;

   snap_t expq[$];
   int    cycq[$];
   string nameq[$];

   logic [1:0] m_st;
   logic [7:0] m_s1, m_s2;
   logic       m_gf, m_go;
   logic [1:0] m_win;

   air_hockey_scoreboard_if bus();

   air_hockey_scoreboard #(.WIN_SCORE(12), .HOLD_TICKS(60)) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic snap_t snap();
      snap_t s;
      s.st  = bus.state;
      s.s1  = bus.score1;
      s.s2  = bus.score2;
      s.frz = bus.freeze;
      s.gf  = bus.goal_flash;
      s.pr  = bus.puck_reset;
      s.go  = bus.game_over;
      s.win = bus.winner;
      return s;
   endfunction

   function automatic snap_t mk(input logic pr);
      snap_t s;
      s.st  = m_st;
      s.s1  = m_s1;
      s.s2  = m_s2;
      s.frz = (m_st != PLAY);
      s.gf  = m_gf;
      s.pr  = pr;
      s.go  = m_go;
      s.win = m_win;
      return s;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] t, o;
      t = v[7:4];
      o = v[3:0];
      if (v == 8'h99) return v;
      if (o == 4'd9) return {t + 4'd1, 4'd0};
      return {t, o + 4'd1};
   endfunction

   task automatic push(input snap_t s, input int c, input string n);
      expq.push_back(s);
      cycq.push_back(c);
      nameq.push_back(n);
   endtask

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_st  = HOLD;
      m_s1  = 8'h00;
      m_s2  = 8'h00;
      m_gf  = 1'b0;
      m_go  = 1'b0;
      m_win = 2'b00;
   endtask

   initial begin
      snap_t cur;
      forever begin
         @(negedge clk);
         cur = snap();
         if (mon_en && cur !== last) begin
            last = cur;
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change got=%h cyc=%0d", cur, cyc);
            end else begin
               snap_t e;
               int    ec;
               string en;
               e  = expq.pop_front();
               ec = cycq.pop_front();
               en = nameq.pop_front();
               if (cur !== e || cyc != ec) begin
                  bad++;
                  $display("FAIL %s got=%h@%0d want=%h@%0d", en, cur, cyc, e, ec);
               end
            end
         end
      end
   end

   // n game ticks; when expire is set the last one ends HOLD
   task automatic hold_run(input int n, input bit expire);
      for (int i = 0; i < n; i++) begin
         bus.prev_clk_cursor = 1'b0;
         bus.clk_cursor      = 1'b1;
         if (expire && i == n - 1) begin
            m_st = PLAY;
            m_gf = 1'b0;
            push(mk(1'b1), cyc + 1, "hold_exit");
            push(mk(1'b0), cyc + 2, "puck_pulse_end");
         end
         step();
         bus.prev_clk_cursor = 1'b1;
         bus.clk_cursor      = 1'b0;
         step();
      end
      bus.prev_clk_cursor = 1'b0;
      bus.clk_cursor      = 1'b0;
      step();
   endtask

   task automatic score_goal(input int side);
      bit won;
      if (side == 1) begin
         bus.collide1 = 1'b1;
         m_s2 = bcd_inc(m_s2);
         won  = (m_s2 == WIN_BCD);
         if (won) m_win = 2'b10;
      end else begin
         bus.collide2 = 1'b1;
         m_s1 = bcd_inc(m_s1);
         won  = (m_s1 == WIN_BCD);
         if (won) m_win = 2'b01;
      end
      if (won) begin
         m_st = OVER;
         m_go = 1'b1;
      end else begin
         m_st = HOLD;
         m_gf = 1'b1;
      end
      push(mk(1'b0), cyc + 1, "goal");
      step();
   endtask

   task automatic drop();
      bus.collide1 = 1'b0;
      bus.collide2 = 1'b0;
      step();
   endtask

   task automatic reset_check(input string n);
      snap_t r;
      model_reset();
      r = mk(1'b0);
      chk(n, 32'(snap()), 32'(r));
      last = r;
   endtask

   initial begin
      bus.prev_clk_cursor = 1'b0;
      bus.clk_cursor      = 1'b0;
      bus.collide1        = 1'b0;
      bus.collide2        = 1'b0;
      bus.restart         = 1'b0;
      step();
      reset_check("reset_state");
      clr = 1'b0;
      step();
      mon_en = 1'b1;
      hold_run(60, 1'b1);

      // collide1 held over 3 ticks scores once
      score_goal(1);
      chk("goal1_score2", 32'(bus.score2), 32'h01);
      hold_run(3, 1'b0);
      drop();
      hold_run(57, 1'b1);

      score_goal(2);
      drop();
      hold_run(60, 1'b1);

      bus.collide1 = 1'b1;
      bus.collide2 = 1'b1;
      step();
      step();
      drop();
      chk("simul_state", 32'(bus.state), 32'(PLAY));
      chk("simul_s1", 32'(bus.score1), 32'h01);
      chk("simul_s2", 32'(bus.score2), 32'h01);

      // rise during HOLD, held into PLAY, never scores
      score_goal(2);
      drop();
      bus.collide1 = 1'b1;
      hold_run(60, 1'b1);
      step();
      step();
      chk("held_s2", 32'(bus.score2), 32'h01);
      drop();

      for (int i = 0; i < 7; i++) begin
         score_goal(2);
         drop();
         hold_run(60, 1'b1);
      end
      chk("pre_carry", 32'(bus.score1), 32'h09);
      score_goal(2);
      chk("bcd_carry", 32'(bus.score1), 32'h10);
      drop();
      hold_run(60, 1'b1);
      score_goal(2);
      drop();
      hold_run(60, 1'b1);
      score_goal(2);
      drop();
      chk("win_state", 32'(bus.state), 32'(OVER));
      chk("win_winner", 32'(bus.winner), 32'h1);

      bus.collide1 = 1'b1;
      step();
      step();
      drop();
      chk("over_ignore_s2", 32'(bus.score2), 32'h01);
      chk("over_hold", 32'(bus.state), 32'(OVER));

      bus.restart = 1'b1;
      model_reset();
      push(mk(1'b0), cyc + 1, "restart");
      step();
      bus.restart = 1'b0;
      step();
      chk("restart_go", 32'(bus.game_over), 32'h0);
      hold_run(60, 1'b1);

      // async clear partway through a HOLD
      score_goal(1);
      drop();
      hold_run(3, 1'b0);
      mon_en = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      reset_check("mid_clr");
      step();
      clr = 1'b0;
      step();
      mon_en = 1'b1;
      hold_run(60, 1'b1);
      step();
      chk("pending", 32'(expq.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
